// File: rtl/stage_if.sv
// stage_if: instruction-fetch stage with internal word-addressed instruction
// memory and the IF/ID pipeline register feeding decode.
// Optional build macro FETCH_COUNT_EN adds the fetch_count output, a count of
// real instructions loaded into IF/ID.
module stage_if #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          branch_taken,
  input  logic [31:0]                   branch_target,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   out_instr,
  output logic [31:0]                   out_pc_plus4,
  output logic [4:0]                    out_rs,
  output logic [4:0]                    out_rt,
  output logic [4:0]                    out_rd,
  output logic                          out_valid,
  output logic [31:0]                   pc
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]                   fetch_count
`endif
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] fetchWord;
  logic [31:0] pcPlus4;
  logic        loadReal;
  logic        unusedTargetBits;

  // Target is forced word-aligned, so its low two bits never matter.
  assign unusedTargetBits = &{1'b0, branch_target[1:0]};

  // Combinational fetch; upper PC bits are dropped so the index wraps.
  assign fetchWord = imem[pc[AW+1:2]];
  assign pcPlus4   = pc + 32'd4;
  assign loadReal  = !flush && !stall;

  // Decode field slices come straight off the registered instruction.
  assign out_rs = out_instr[25:21];
  assign out_rt = out_instr[20:16];
  assign out_rd = out_instr[15:11];

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  // PC register: branch redirect beats stall, otherwise sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= {branch_target[31:2], 2'b00};
    end else if (!stall) begin
      pc <= pcPlus4;
    end
  end

  // IF/ID register: flush inserts a bubble and beats stall, stall holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_instr    <= '0;
      out_pc_plus4 <= '0;
      out_valid    <= 1'b0;
    end else if (flush) begin
      out_instr    <= '0;
      out_pc_plus4 <= '0;
      out_valid    <= 1'b0;
    end else if (!stall) begin
      out_instr    <= fetchWord;
      out_pc_plus4 <= pcPlus4;
      out_valid    <= 1'b1;
    end
  end

`ifdef FETCH_COUNT_EN
  // Count every edge on which IF/ID takes a real instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (loadReal) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`else
  logic unusedLoadReal;
  assign unusedLoadReal = loadReal;
`endif

endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if: directed-vector bench for stage_if with hand-computed values.
module tb_stage_if;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic          flush;
  logic          branch_taken;
  logic [31:0]   branch_target;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc_plus4;
  logic [4:0]    out_rs;
  logic [4:0]    out_rt;
  logic [4:0]    out_rd;
  logic          out_valid;
  logic [31:0]   pc;
`ifdef FETCH_COUNT_EN
  logic [31:0]   fetch_count;
`endif

  int unsigned checks = 0;
  int unsigned fails  = 0;

  stage_if #(
    .IMEM_DEPTH(DEPTH),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .out_instr    (out_instr),
    .out_pc_plus4 (out_pc_plus4),
    .out_rs       (out_rs),
    .out_rt       (out_rt),
    .out_rd       (out_rd),
    .out_valid    (out_valid),
    .pc           (pc)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count  (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeWord(input logic [AW-1:0] addr, input logic [31:0] data);
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = data;
    tick();
    imem_we    = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    branch_taken  = 1'b1;
    flush         = 1'b1;
    branch_target = target;
    tick();
    branch_taken  = 1'b0;
    flush         = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
    branch_target = '0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;

    // Preload while held in reset.
    writeWord(6'd0,  32'h012A4020);
    writeWord(6'd1,  32'h8C090004);
    writeWord(6'd2,  32'hAC0A0008);
    writeWord(6'd3,  32'h00000000);
    writeWord(6'd4,  32'h00221820);
    writeWord(6'd63, 32'hDEADBEEF);

    checkEq("rst_pc",     pc, 32'h0);
    checkEq("rst_instr",  out_instr, 32'h0);
    checkEq("rst_pc4",    out_pc_plus4, 32'h0);
    checkEq("rst_valid",  {31'b0, out_valid}, 32'h0);
    checkEq("rst_rs",     {27'b0, out_rs}, 32'h0);

    rst_n = 1'b1;
    tick();
    checkEq("e1_instr", out_instr, 32'h012A4020);
    checkEq("e1_rs",    {27'b0, out_rs}, 32'd9);
    checkEq("e1_rt",    {27'b0, out_rt}, 32'd10);
    checkEq("e1_rd",    {27'b0, out_rd}, 32'd8);
    checkEq("e1_pc4",   out_pc_plus4, 32'd4);
    checkEq("e1_valid", {31'b0, out_valid}, 32'd1);
    checkEq("e1_pc",    pc, 32'd4);

    tick();
    checkEq("e2_instr", out_instr, 32'h8C090004);
    checkEq("e2_pc",    pc, 32'd8);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkEq("stall_pc",    pc, 32'd8);
      checkEq("stall_instr", out_instr, 32'h8C090004);
    end
    stall = 1'b0;
    tick();
    checkEq("unstall_instr", out_instr, 32'hAC0A0008);
    checkEq("unstall_pc4",   out_pc_plus4, 32'd12);
    checkEq("unstall_pc",    pc, 32'd12);

    redirect(32'h0000_0013);
    checkEq("br_pc",    pc, 32'h10);
    checkEq("br_instr", out_instr, 32'h0);
    checkEq("br_valid", {31'b0, out_valid}, 32'h0);
    tick();
    checkEq("br_next_instr", out_instr, 32'h00221820);
    checkEq("br_next_pc4",   out_pc_plus4, 32'h14);
    checkEq("br_next_valid", {31'b0, out_valid}, 32'd1);

    stall = 1'b1; flush = 1'b1;
    tick();
    checkEq("sf_pc",    pc, 32'h14);
    checkEq("sf_instr", out_instr, 32'h0);
    checkEq("sf_valid", {31'b0, out_valid}, 32'h0);
    stall = 1'b0; flush = 1'b0;

    redirect(32'h0000_0100);
    checkEq("wrap_pc", pc, 32'h100);
    tick();
    checkEq("wrap_instr", out_instr, 32'h012A4020);
    checkEq("wrap_pc4",   out_pc_plus4, 32'h104);

    redirect(32'hFFFF_FFFC);
    checkEq("top_pc", pc, 32'hFFFF_FFFC);
    tick();
    checkEq("top_wrap_pc",    pc, 32'h0);
    checkEq("top_wrap_instr", out_instr, 32'hDEADBEEF);
    checkEq("top_wrap_pc4",   out_pc_plus4, 32'h0);

    redirect(32'h0000_0008);
    checkEq("coll_pc", pc, 32'h8);
    imem_we = 1'b1; imem_waddr = 6'd2; imem_wdata = 32'hCAFEF00D;
    tick();
    imem_we = 1'b0;
    checkEq("coll_old", out_instr, 32'hAC0A0008);
    redirect(32'h0000_0008);
    tick();
    checkEq("coll_new", out_instr, 32'hCAFEF00D);
    checkEq("pre_arst_valid", {31'b0, out_valid}, 32'd1);

    #3;
    rst_n = 1'b0;
    #1;
    checkEq("arst_pc",    pc, 32'h0);
    checkEq("arst_instr", out_instr, 32'h0);
    checkEq("arst_pc4",   out_pc_plus4, 32'h0);
    checkEq("arst_valid", {31'b0, out_valid}, 32'h0);
    checkEq("arst_rd",    {27'b0, out_rd}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
